// File: rtl/dbus_arbiter.sv
// N-channel data-bus arbiter: registered, handshaked merge of requesters onto dreq/dresp.
// Each grant is held from IDLE through BUSY until data_ok, then resp_ok pulses once in RESP.
module dbus_arbiter #(
    parameter int unsigned NCH = 2,
    parameter int unsigned AW  = 64,
    parameter int unsigned DW  = 64,
    parameter int unsigned SW  = DW / 8,
    parameter bit          RR  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    req_valid,
    input  logic [NCH*AW-1:0] req_addr,
    input  logic [NCH*3-1:0]  req_size,
    input  logic [NCH*DW-1:0] req_data,
    input  logic [NCH*SW-1:0] req_strobe,
    output logic [NCH-1:0]    resp_ok,
    output logic [DW-1:0]     resp_data,
    output logic              dreq_valid,
    output logic [AW-1:0]     dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [DW-1:0]     dreq_data,
    output logic [SW-1:0]     dreq_strobe,
    input  logic              dresp_data_ok,
    input  logic [DW-1:0]     dresp_data
);

    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;

    logic            dreq_valid_d;
    logic [AW-1:0]   dreq_addr_d;
    logic [2:0]      dreq_size_d;
    logic [DW-1:0]   dreq_data_d;
    logic [SW-1:0]   dreq_strobe_d;
    logic [NCH-1:0]  resp_ok_d;
    logic [DW-1:0]   resp_data_d;

    logic            found;
    logic [PW-1:0]   win;
    logic [PW:0]     cand_ext;
    logic [PW-1:0]   cand;

    logic [AW-1:0]   ch_addr   [NCH];
    logic [2:0]      ch_size   [NCH];
    logic [DW-1:0]   ch_data   [NCH];
    logic [SW-1:0]   ch_strobe [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_slice
        assign ch_addr[g]   = req_addr[g*AW +: AW];
        assign ch_size[g]   = req_size[g*3 +: 3];
        assign ch_data[g]   = req_data[g*DW +: DW];
        assign ch_strobe[g] = req_strobe[g*SW +: SW];
    end

    // Scan starts at rr_ptr (round-robin) or 0 (fixed), wrapping past NCH-1 for any NCH.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        cand_ext = '0;
        cand     = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (RR) begin
                cand_ext = {1'b0, rr_ptr_q} + (PW+1)'(i);
                if (cand_ext >= (PW+1)'(NCH))
                    cand_ext = cand_ext - (PW+1)'(NCH);
            end else begin
                cand_ext = (PW+1)'(i);
            end
            cand = cand_ext[PW-1:0];
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            dreq_valid  <= 1'b0;
            dreq_addr   <= '0;
            dreq_size   <= '0;
            dreq_data   <= '0;
            dreq_strobe <= '0;
            resp_ok     <= '0;
            resp_data   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            dreq_valid  <= dreq_valid_d;
            dreq_addr   <= dreq_addr_d;
            dreq_size   <= dreq_size_d;
            dreq_data   <= dreq_data_d;
            dreq_strobe <= dreq_strobe_d;
            resp_ok     <= resp_ok_d;
            resp_data   <= resp_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = BUSY;
            BUSY:    if (dresp_data_ok) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        dreq_valid_d  = dreq_valid;
        dreq_addr_d   = dreq_addr;
        dreq_size_d   = dreq_size;
        dreq_data_d   = dreq_data;
        dreq_strobe_d = dreq_strobe;
        resp_ok_d     = '0;
        resp_data_d   = resp_data;
        case (state_q)
            IDLE: begin
                if (found) begin
                    dreq_valid_d  = 1'b1;
                    dreq_addr_d   = ch_addr[win];
                    dreq_size_d   = ch_size[win];
                    dreq_data_d   = ch_data[win];
                    dreq_strobe_d = ch_strobe[win];
                    grant_d       = win;
                    if (RR)
                        rr_ptr_d = (win == PW'(NCH-1)) ? '0 : win + PW'(1);
                end else begin
                    dreq_valid_d = 1'b0;
                end
            end
            BUSY: begin
                if (dresp_data_ok) begin
                    resp_data_d        = dresp_data;
                    resp_ok_d[grant_q] = 1'b1;
                    dreq_valid_d       = 1'b0;
                end
            end
            RESP:    dreq_valid_d = 1'b0;
            default: dreq_valid_d = 1'b0;
        endcase
    end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Parametrised N-channel arbiter that merges several data-bus requesters onto the single core data bus (dreq/dresp).
- Requesters include the memory-stage read port, the memory-stage write port, and future page-walker and cache-refill ports.
- Replaces the combinational read/write mux with a registered, handshaked arbiter.
- Supports round-robin or fixed-priority mode and holds each grant until the bus returns data_ok.

Parameters:
NCH, 2, number of requesting channels (≥2); channel 0 is highest priority in fixed mode
AW, 64, address width
DW, 64, data width
SW, DW/8, strobe width
RR, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_valid  in  NCH  per-channel request valid; held high until that channel's resp_ok
req_addr  in  NCH*AW  per-channel address, channel i at [i*AW +: AW]
req_size  in  NCH*3  per-channel access size (log2 bytes)
req_data  in  NCH*DW  per-channel write data
req_strobe  in  NCH*SW  per-channel byte strobe; all-zero means read
resp_ok  out  NCH  one-cycle completion pulse for channel i
resp_data  out  DW  read data, valid when any resp_ok bit is high
dreq_valid  out  1  downstream request valid
dreq_addr  out  AW  downstream address
dreq_size  out  3  downstream size
dreq_data  out  DW  downstream write data
dreq_strobe  out  SW  downstream strobe
dresp_data_ok  in  1  downstream completion
dresp_data  in  DW  downstream read data

Behaviour:
- Clock and reset: clk is the only clock. reset is asynchronous and active-low.
- Reset values (reset=0, immediate and independent of clk):
  - state=IDLE, dreq_valid=0, dreq_addr/size/data/strobe=0.
  - resp_ok=0, resp_data=0.
  - grant=0, rr_ptr=0.
- All outputs are registered.
- FSM:
  - IDLE: if any req_valid is high, select a winner, latch its addr/size/data/strobe into the dreq registers, set dreq_valid=1, record grant, go to BUSY. Otherwise stay in IDLE with dreq_valid=0.
  - BUSY: dreq_* are held stable, whatever req_* do. When dresp_data_ok=1, register resp_data<=dresp_data, set resp_ok[grant]=1, clear dreq_valid, go to RESP.
  - RESP: resp_ok is high for exactly this cycle. Next state is IDLE, with resp_ok cleared. No arbitration happens in RESP, so the requester can retire or replace its request at the edge that ends RESP.
- Winner selection:
  - RR=0: the lowest-index valid channel wins.
  - RR=1: the first valid channel scanning from rr_ptr upward with wrap (index NCH-1 → 0). On grant, rr_ptr <= (winner+1) mod NCH.
  - rr_ptr is not updated when no channel is valid.
- Latency:
  - With req_valid high in IDLE at cycle t, dreq_valid=1 from cycle t+1.
  - With dresp_data_ok seen at cycle k, resp_ok is high in cycle k+1.
  - Minimum turnaround is 3 cycles per transaction (IDLE, BUSY, RESP) when data_ok arrives in the first BUSY cycle.
- Boundary conditions:
  - dresp_data_ok in IDLE or RESP is ignored.
  - If the granted channel drops req_valid during BUSY, the transaction still completes and resp_ok still pulses (no abort).
  - New req_valid assertions on other channels during BUSY/RESP wait. They are arbitrated only in IDLE.
  - Multiple simultaneous valid channels: exactly one is granted. Under RR, no channel waits more than NCH-1 grants.
  - resp_ok is one-hot or zero, never multi-bit.
  - Reset asserted mid-transaction: everything returns immediately to reset values. The outstanding downstream transaction is abandoned, and a late data_ok after reset release is ignored because the FSM is in IDLE.
  - Width rules: channel slices are selected by index multiplication. NCH that is not a power of two must wrap correctly (ptr==NCH-1 → 0).

Test Plan:
- Single read, NCH=2, RR=1: ch0 valid, addr=0x8000_1000, strobe=0; data_ok after 2 BUSY cycles with data 0xDEAD_BEEF → dreq_valid high 2 cycles, dreq_addr=0x8000_1000, resp_ok=2'b01 for 1 cycle, resp_data=0xDEAD_BEEF.
- Contention, RR=1: ch0 and ch1 continuously valid, each request retired after resp_ok → grants alternate 0,1,0,1; with RR=0, all grants go to ch0 while it stays valid.
- Write passthrough: ch1 addr=0x8000_2008, size=3, data=0x1122_3344_5566_7788, strobe=0xFF → dreq fields match exactly and stay stable through 5 BUSY cycles while ch1 inputs change.
- Wrap, NCH=3, RR=1: rr_ptr=2, only ch0 and ch1 valid → ch0 granted, rr_ptr becomes 1.
- Reset mid-op: async reset=0 in BUSY → dreq_valid=0 before the next clk edge; data_ok=1 in the first cycle after release → resp_ok stays 0.
- Spurious data_ok in IDLE with no requests → no resp_ok, state stays IDLE, resp_data unchanged.
